bmp_binarize_engine: RTL and testbench
======================================

// Module: bmp_binarize_engine
// PURPOSE
//  Initiator for the BMP dual-port RAM: parses the 24bpp BMP header already in RAM,
//  then binarizes every pixel in place. Port 1 is used read-only, port 2 write-only.
//  Sits between the top-level BMP load/dump testbench flow and the RAM; start/done handshake to top.
// PARAMETERS
//  ADDR_WIDTH   `ADDR_WIDTH      RAM byte-address width
//  BYTE_WIDTH   `BYTE_WIDTH (8)  RAM data width; engine logic fixed at 8
//  TOTAL_SIZE   `BMP_TOTAL_SIZE  last legal byte address + 1 (bounds check)
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           synchronous, active-high reset
//  start      in   1           start request; accepted only in IDLE
//  thr        in   8           binarize threshold, captured on start accept
//  busy       out  1           high from cycle after accept until DONE
//  done       out  1           one-cycle pulse at end of job
//  err        out  1           valid with done: image exceeds TOTAL_SIZE, no pixel written
//  RAM_ren1   out  1           port-1 read enable (RAM_wen1 tied 0)
//  RAM_wen1   out  1           constant 0
//  RAM_addr1  out  ADDR_WIDTH  port-1 read address
//  RAM_out1   in   BYTE_WIDTH  port-1 read data, valid 1 cycle after address while RAM_ren1=1
//  RAM_ren2   out  1           constant 0
//  RAM_wen2   out  1           port-2 write enable
//  RAM_addr2  out  ADDR_WIDTH  port-2 write address
//  RAM_in2    out  BYTE_WIDTH  port-2 write data
// BEHAVIOUR
//  - Reset: state IDLE; busy, done, err, RAM_ren1, RAM_wen2 = 0; addresses, RAM_in2, regs = 0.
//  - Read protocol: RAM gates data with ren, so RAM_ren1 held high through the data cycle; reads
//    pipelined 1/cycle, data for addr issued in cycle t sampled at end of cycle t+1.
//  - FSM: IDLE -> HDR -> SETUP -> (PIX_RD -> PIX_CALC -> PIX_WR)* -> DONE -> IDLE.
//  - HDR (7 cycles): read bytes 10,11 (pixel offset), 18,19 (width W), 22,23 (height H), little-
//    endian, low 16 bits only; 6 issue cycles + 1 drain.
//  - SETUP (1 cycle): stride = (3*W+3) & ~3; end = offset + stride*H (24-bit arithmetic).
//    end > TOTAL_SIZE -> DONE with err=1. W==0 or H==0 -> DONE, err=0, no writes.
//  - PIX_RD (4 cycles): read B,G,R at p, p+1, p+2, + drain. PIX_CALC (1): 16-bit
//    sum = 29*B + 150*G + 77*R; gray = sum[15:8]; bin = (gray >= thr) ? 8'hFF : 8'h00.
//  - PIX_WR (3): RAM_wen2=1, write bin to p, p+1, p+2, one per cycle.
//  - Address walk: p += 3 per pixel; after column W-1, p = row_base + stride (padding bytes never
//    read or written); after row H-1 -> DONE.
//  - Port 1/2 never touch the same address in the same cycle (writes only after that pixel's reads).
//  - Timing: start accepted at edge k -> busy=1 from cycle k+1; done=1 in cycle k+9+8*W*H;
//    busy=0 in that same DONE cycle; IDLE next cycle.
//  - start while busy ignored; start held high re-triggers a new job after DONE.
//  - thr change mid-job ignored. rst mid-job: immediate IDLE, RAM left partially written.
// STRUCTURE
//  - DEFINE.vh: ADDR_WIDTH, BYTE_WIDTH, BMP_TOTAL_SIZE, header field offsets (10,18,22),
//    luma coefficients (29,150,77), FSM state encodings.
//  - Sub-module bmp_gray_threshold: registered B,G,R,thr -> bin byte (used in PIX_CALC).
//  - Top FSM, header regs, row/column counters, address generator in this module.
// TESTING
//  - 1x1, offset 54, pixel (B,G,R)=(0,0,255), thr=128 -> gray 76, bytes 54..56 = 00; pad 57 (0xAA) unchanged.
//  - Same pixel (255,255,255) -> gray 255 -> 54..56 = FF; done in cycle k+17.
//  - Pixel (100,128,200): thr=128 -> FF; rerun with thr=147 -> 00 (gray 146).
//  - 2x2, W=2 stride 8: rows at 54 and 62; bytes 60,61,68,69 unchanged; done at k+41.
//  - Header W=1000,H=1000 in 4 KiB RAM -> done with err=1, zero port-2 writes; W=0 -> done, err=0, k+9.
//  - rst asserted mid PIX_WR -> next cycle all outputs 0; new start completes correctly; start during busy ignored.

Source files
------------

// File: rtl/bmp_binarize_engine_pkg.sv
// Shared constants, FSM encoding and header address lookup for the BMP binarize engine.
// No logic of its own; no latency.
// No flow control.
package bmp_binarize_engine_pkg;

  localparam int ADDR_WIDTH_DEF = 12;
  localparam int BYTE_WIDTH_DEF = 8;
  localparam int TOTAL_SIZE_DEF = 4096;

  // Little-endian 16-bit header fields of a BMP file
  localparam logic [7:0] HDR_OFF_ADDR = 8'd10;
  localparam logic [7:0] HDR_W_ADDR   = 8'd18;
  localparam logic [7:0] HDR_H_ADDR   = 8'd22;

  // Integer luma weights scaled so that they sum to 256
  localparam logic [7:0] COEF_B = 8'd29;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_R = 8'd77;

  // Last phase count of each multi-cycle state
  localparam logic [2:0] HDR_LAST = 3'd6;
  localparam logic [2:0] RD_LAST  = 3'd3;
  localparam logic [2:0] WR_LAST  = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR      = 3'd1,
    ST_SETUP    = 3'd2,
    ST_PIX_RD   = 3'd3,
    ST_PIX_CALC = 3'd4,
    ST_PIX_WR   = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  // Header byte read in each issue cycle; the drain cycle repeats the last address
  function automatic logic [7:0] hdr_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    return HDR_OFF_ADDR;
      3'd1:    return HDR_OFF_ADDR + 8'd1;
      3'd2:    return HDR_W_ADDR;
      3'd3:    return HDR_W_ADDR + 8'd1;
      3'd4:    return HDR_H_ADDR;
      default: return HDR_H_ADDR + 8'd1;
    endcase
  endfunction

endpackage

// File: rtl/bmp_gray_threshold.sv
// Luma of a registered B,G,R triple compared against a threshold, giving an all-ones/all-zeros byte.
// One cycle: result registered on the edge that ends the enable cycle.
// No flow control; holds its output while en is low.
module bmp_gray_threshold
  import bmp_binarize_engine_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] b,
  input  logic [7:0] g,
  input  logic [7:0] r,
  input  logic [7:0] thr,
  output logic [7:0] bin
);

  logic [15:0] sum;
  logic [7:0]  gray;

  // Weighted sum fits 16 bits because the weights add up to 256
  always_comb begin
    sum  = 16'(b) * 16'(COEF_B) + 16'(g) * 16'(COEF_G) + 16'(r) * 16'(COEF_R);
    gray = 8'(sum >> 8);
  end

  // Register the binarized byte for the write phase
  always_ff @(posedge clk) begin
    if (rst) begin
      bin <= 8'h00;
    end else if (en) begin
      bin <= (gray >= thr) ? 8'hFF : 8'h00;
    end
  end

endmodule

// File: rtl/bmp_binarize_engine.sv
// Parses a 24bpp BMP header from RAM and binarizes every pixel in place (port 1 reads, port 2 writes).
// Latency: done in cycle k+9+8*W*H after start is accepted at edge k.
// No backpressure: start is only taken in IDLE; RAM is assumed always ready.
module bmp_binarize_engine
  import bmp_binarize_engine_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int BYTE_WIDTH = BYTE_WIDTH_DEF,
  parameter int TOTAL_SIZE = TOTAL_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            thr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  RAM_ren1,
  output logic                  RAM_wen1,
  output logic [ADDR_WIDTH-1:0] RAM_addr1,
  input  logic [BYTE_WIDTH-1:0] RAM_out1,
  output logic                  RAM_ren2,
  output logic                  RAM_wen2,
  output logic [ADDR_WIDTH-1:0] RAM_addr2,
  output logic [BYTE_WIDTH-1:0] RAM_in2
);

  state_t                state_q, state_d;
  logic [2:0]            cnt_q;
  logic [7:0]            thr_q, b_q, g_q, r_q;
  logic [15:0]           off_q, w_q, h_q, col_q, row_q;
  logic [ADDR_WIDTH-1:0] stride_q, p_q, row_base_q;
  logic                  err_q;
  logic [7:0]            bin;
  logic [7:0]            rd_byte;
  logic [23:0]           off24, w24, h24, stride_c, end_c;
  logic                  size_err, empty_img, last_col, last_row;

  assign RAM_wen1 = 1'b0;
  assign RAM_ren2 = 1'b0;
  assign rd_byte  = RAM_out1[7:0];

  // Image geometry: rows padded to 4 bytes, all arithmetic in 24 bits
  always_comb begin
    off24     = {8'd0, off_q};
    w24       = {8'd0, w_q};
    h24       = {8'd0, h_q};
    stride_c  = (w24 + w24 + w24 + 24'd3) & 24'hFF_FFFC;
    end_c     = off24 + stride_c * h24;
    size_err  = end_c > 24'(TOTAL_SIZE);
    empty_img = (w_q == 16'd0) || (h_q == 16'd0);
    last_col  = col_q == (w_q - 16'd1);
    last_row  = row_q == (h_q - 16'd1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: header, setup, then an 8-cycle read/calc/write loop per pixel
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start) state_d = ST_HDR;
      ST_HDR:      if (cnt_q == HDR_LAST) state_d = ST_SETUP;
      ST_SETUP:    state_d = (size_err || empty_img) ? ST_DONE : ST_PIX_RD;
      ST_PIX_RD:   if (cnt_q == RD_LAST) state_d = ST_PIX_CALC;
      ST_PIX_CALC: state_d = ST_PIX_WR;
      ST_PIX_WR:   if (cnt_q == WR_LAST) state_d = (last_col && last_row) ? ST_DONE : ST_PIX_RD;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Phase counter, header capture, pixel capture and address walk
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 3'd0;
      thr_q      <= 8'd0;
      b_q        <= 8'd0;
      g_q        <= 8'd0;
      r_q        <= 8'd0;
      off_q      <= 16'd0;
      w_q        <= 16'd0;
      h_q        <= 16'd0;
      col_q      <= 16'd0;
      row_q      <= 16'd0;
      stride_q   <= '0;
      p_q        <= '0;
      row_base_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q <= (state_d != state_q) ? 3'd0 : cnt_q + 3'd1;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            thr_q <= thr;
            err_q <= 1'b0;
          end
        end
        ST_HDR: begin
          // Read data lags its address by one cycle
          case (cnt_q)
            3'd1:    off_q[7:0]  <= rd_byte;
            3'd2:    off_q[15:8] <= rd_byte;
            3'd3:    w_q[7:0]    <= rd_byte;
            3'd4:    w_q[15:8]   <= rd_byte;
            3'd5:    h_q[7:0]    <= rd_byte;
            3'd6:    h_q[15:8]   <= rd_byte;
            default: ;
          endcase
        end
        ST_SETUP: begin
          stride_q   <= stride_c[ADDR_WIDTH-1:0];
          err_q      <= size_err;
          p_q        <= off24[ADDR_WIDTH-1:0];
          row_base_q <= off24[ADDR_WIDTH-1:0];
          col_q      <= 16'd0;
          row_q      <= 16'd0;
        end
        ST_PIX_RD: begin
          case (cnt_q)
            3'd1:    b_q <= rd_byte;
            3'd2:    g_q <= rd_byte;
            3'd3:    r_q <= rd_byte;
            default: ;
          endcase
        end
        ST_PIX_WR: begin
          // Row end jumps over padding to the next row base
          if (cnt_q == WR_LAST && !(last_col && last_row)) begin
            if (last_col) begin
              col_q      <= 16'd0;
              row_q      <= row_q + 16'd1;
              row_base_q <= row_base_q + stride_q;
              p_q        <= row_base_q + stride_q;
            end else begin
              col_q <= col_q + 16'd1;
              p_q   <= p_q + ADDR_WIDTH'(3);
            end
          end
        end
        default: ;
      endcase
    end
  end

  bmp_gray_threshold u_gray (
    .clk (clk),
    .rst (rst),
    .en  (state_q == ST_PIX_CALC),
    .b   (b_q),
    .g   (g_q),
    .r   (r_q),
    .thr (thr_q),
    .bin (bin)
  );

  // Outputs decoded from state; read enable stays high through each drain cycle
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    RAM_ren1  = 1'b0;
    RAM_addr1 = '0;
    RAM_wen2  = 1'b0;
    RAM_addr2 = '0;
    RAM_in2   = '0;
    case (state_q)
      ST_HDR: begin
        busy      = 1'b1;
        RAM_ren1  = 1'b1;
        RAM_addr1 = ADDR_WIDTH'(hdr_addr(cnt_q));
      end
      ST_SETUP, ST_PIX_CALC: busy = 1'b1;
      ST_PIX_RD: begin
        busy      = 1'b1;
        RAM_ren1  = 1'b1;
        RAM_addr1 = p_q + ADDR_WIDTH'((cnt_q > 3'd2) ? 3'd2 : cnt_q);
      end
      ST_PIX_WR: begin
        busy      = 1'b1;
        RAM_wen2  = 1'b1;
        RAM_addr2 = p_q + ADDR_WIDTH'(cnt_q);
        RAM_in2   = BYTE_WIDTH'(bin);
      end
      ST_DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bmp_binarize_engine.sv
// Directed bench for bmp_binarize_engine with a dual-port RAM model.
// Checks latency, written bytes, padding, bounds error, reset and start handling.
// RAM model never stalls.
module tb_bmp_binarize_engine;

  localparam int AW = 12;
  localparam int BW = 8;
  localparam int TS = 4096;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [7:0]    thr;
  logic          busy, done, err;
  logic          RAM_ren1, RAM_wen1, RAM_ren2, RAM_wen2;
  logic [AW-1:0] RAM_addr1, RAM_addr2;
  logic [BW-1:0] RAM_out1, RAM_in2;

  logic [7:0]    mem [0:TS-1];
  logic [7:0]    rdata_q = 8'h00;
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_wa = '0;
  logic [7:0]    tb_wd = 8'h00;
  int            wr_count = 0;
  int            conflicts = 0;

  int   errors = 0;
  int   checks = 0;
  int   lat, nwr, n;
  logic b1, e_at, b_at;

  always #5 clk = ~clk;

  bmp_binarize_engine #(.ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .TOTAL_SIZE(TS)) dut (
    .clk(clk), .rst(rst), .start(start), .thr(thr),
    .busy(busy), .done(done), .err(err),
    .RAM_ren1(RAM_ren1), .RAM_wen1(RAM_wen1), .RAM_addr1(RAM_addr1), .RAM_out1(RAM_out1),
    .RAM_ren2(RAM_ren2), .RAM_wen2(RAM_wen2), .RAM_addr2(RAM_addr2), .RAM_in2(RAM_in2)
  );

  // RAM: read data registered and only driven while ren1 is held
  assign RAM_out1 = RAM_ren1 ? rdata_q : 8'h00;

  always @(posedge clk) begin
    if (RAM_ren1) rdata_q <= mem[RAM_addr1];
    if (RAM_wen2) begin
      mem[RAM_addr2] <= RAM_in2;
      wr_count <= wr_count + 1;
    end else if (tb_we) begin
      mem[tb_wa] <= tb_wd;
    end
    if (RAM_ren1 && RAM_wen2 && RAM_addr1 == RAM_addr2) conflicts <= conflicts + 1;
  end

  task automatic wb(input int a, input logic [7:0] d);
    tb_wa = AW'(a); tb_wd = d; tb_we = 1'b1;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic setup_img(input int off, input int w, input int h);
    logic [15:0] o16, w16, h16;
    o16 = 16'(off); w16 = 16'(w); h16 = 16'(h);
    for (int i = 0; i < 128; i++) wb(i, 8'hAA);
    wb(10, o16[7:0]); wb(11, o16[15:8]);
    wb(18, w16[7:0]); wb(19, w16[15:8]);
    wb(22, h16[7:0]); wb(23, h16[15:8]);
  endtask

  task automatic put_px(input int a, input logic [7:0] b, input logic [7:0] g, input logic [7:0] r);
    wb(a, b); wb(a + 1, g); wb(a + 2, r);
  endtask

  // Start a job at a negedge; latency counts cycles after the accept edge
  task automatic run_job(input logic [7:0] t, output int l, output logic bsy1,
                         output logic e, output logic bd, output int nw);
    int w0;
    w0 = wr_count;
    start = 1'b1; thr = t;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; thr = ~t;
    bsy1 = busy; l = 1;
    while (!done && l < 3000) begin @(negedge clk); l++; end
    e = err; bd = busy;
    @(negedge clk);
    nw = wr_count - w0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; thr = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, err, RAM_ren1, RAM_wen1, RAM_ren2, RAM_wen2} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0", {busy, done, err, RAM_ren1, RAM_wen1, RAM_ren2, RAM_wen2}); end
    checks++; if ({RAM_addr1, RAM_addr2, RAM_in2} !== 32'h0) begin
      errors++; $display("FAIL reset_bus: got %h expected 0", {RAM_addr1, RAM_addr2, RAM_in2}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_dark_pixel;
    setup_img(54, 1, 1); put_px(54, 8'd0, 8'd0, 8'd255);
    run_job(8'd128, lat, b1, e_at, b_at, nwr);
    checks++; if (lat !== 17) begin errors++; $display("FAIL dark_latency: got %0d expected 17", lat); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL dark_busy_first: got %b expected 1", b1); end
    checks++; if (b_at !== 1'b0 || e_at !== 1'b0) begin
      errors++; $display("FAIL dark_done_flags: busy=%b err=%b expected 0 0", b_at, e_at); end
    checks++; if (nwr !== 3) begin errors++; $display("FAIL dark_writes: got %0d expected 3", nwr); end
    checks++; if ({mem[54], mem[55], mem[56], mem[57]} !== 32'h000000AA) begin
      errors++; $display("FAIL dark_bytes: got %h expected 000000aa", {mem[54], mem[55], mem[56], mem[57]}); end
  endtask

  task automatic test_white_pixel;
    setup_img(54, 1, 1); put_px(54, 8'd255, 8'd255, 8'd255);
    run_job(8'd128, lat, b1, e_at, b_at, nwr);
    checks++; if (lat !== 17) begin errors++; $display("FAIL white_latency: got %0d expected 17", lat); end
    checks++; if ({mem[54], mem[55], mem[56], mem[57]} !== 32'hFFFFFFAA) begin
      errors++; $display("FAIL white_bytes: got %h expected ffffffaa", {mem[54], mem[55], mem[56], mem[57]}); end
  endtask

  task automatic test_threshold;
    setup_img(54, 1, 1); put_px(54, 8'd100, 8'd128, 8'd200);
    run_job(8'd128, lat, b1, e_at, b_at, nwr);
    checks++; if ({mem[54], mem[55], mem[56]} !== 24'hFFFFFF) begin
      errors++; $display("FAIL thr128_bytes: got %h expected ffffff", {mem[54], mem[55], mem[56]}); end
    put_px(54, 8'd100, 8'd128, 8'd200);
    run_job(8'd147, lat, b1, e_at, b_at, nwr);
    checks++; if ({mem[54], mem[55], mem[56]} !== 24'h000000) begin
      errors++; $display("FAIL thr147_bytes: got %h expected 000000", {mem[54], mem[55], mem[56]}); end
  endtask

  task automatic test_2x2;
    setup_img(54, 2, 2);
    put_px(54, 8'd0,   8'd0,   8'd0);    // gray 0   -> 00
    put_px(57, 8'd255, 8'd255, 8'd255);  // gray 255 -> FF
    put_px(62, 8'd0,   8'd255, 8'd0);    // gray 149 -> FF
    put_px(65, 8'd0,   8'd0,   8'd255);  // gray 76  -> 00
    run_job(8'd128, lat, b1, e_at, b_at, nwr);
    checks++; if (lat !== 41) begin errors++; $display("FAIL 2x2_latency: got %0d expected 41", lat); end
    checks++; if (nwr !== 12) begin errors++; $display("FAIL 2x2_writes: got %0d expected 12", nwr); end
    checks++; if ({mem[54], mem[55], mem[56], mem[57], mem[58], mem[59]} !== 48'h000000FFFFFF) begin
      errors++; $display("FAIL 2x2_row0: got %h expected 000000ffffff", {mem[54], mem[55], mem[56], mem[57], mem[58], mem[59]}); end
    checks++; if ({mem[62], mem[63], mem[64], mem[65], mem[66], mem[67]} !== 48'hFFFFFF000000) begin
      errors++; $display("FAIL 2x2_row1: got %h expected ffffff000000", {mem[62], mem[63], mem[64], mem[65], mem[66], mem[67]}); end
    checks++; if ({mem[60], mem[61], mem[68], mem[69]} !== 32'hAAAAAAAA) begin
      errors++; $display("FAIL 2x2_padding: got %h expected aaaaaaaa", {mem[60], mem[61], mem[68], mem[69]}); end
  endtask

  task automatic test_size_err;
    setup_img(54, 1000, 1000);
    run_job(8'd128, lat, b1, e_at, b_at, nwr);
    checks++; if (lat !== 9) begin errors++; $display("FAIL err_latency: got %0d expected 9", lat); end
    checks++; if (e_at !== 1'b1) begin errors++; $display("FAIL err_flag: got %b expected 1", e_at); end
    checks++; if (nwr !== 0) begin errors++; $display("FAIL err_writes: got %0d expected 0", nwr); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_after_done: got %b expected 0", err); end
  endtask

  task automatic test_empty;
    setup_img(54, 0, 5);
    run_job(8'd128, lat, b1, e_at, b_at, nwr);
    checks++; if (lat !== 9) begin errors++; $display("FAIL empty_latency: got %0d expected 9", lat); end
    checks++; if (e_at !== 1'b0 || nwr !== 0) begin
      errors++; $display("FAIL empty_result: err=%b writes=%0d expected 0 0", e_at, nwr); end
  endtask

  task automatic test_reset_mid;
    setup_img(54, 1, 1); put_px(54, 8'd255, 8'd255, 8'd255);
    start = 1'b1; thr = 8'd128;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; n = 0;
    while (!RAM_wen2 && n < 50) begin @(negedge clk); n++; end
    checks++; if (RAM_wen2 !== 1'b1) begin errors++; $display("FAIL rstmid_reach_wr: got %b expected 1", RAM_wen2); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({busy, done, err, RAM_ren1, RAM_wen2, RAM_addr1, RAM_addr2, RAM_in2} !== 37'h0) begin
      errors++; $display("FAIL rstmid_outputs: got %h expected 0", {busy, done, err, RAM_ren1, RAM_wen2, RAM_addr1, RAM_addr2, RAM_in2}); end
    rst = 1'b0;
    @(negedge clk);
    setup_img(54, 1, 1); put_px(54, 8'd0, 8'd0, 8'd255);
    run_job(8'd128, lat, b1, e_at, b_at, nwr);
    checks++; if (lat !== 17 || {mem[54], mem[55], mem[56]} !== 24'h000000) begin
      errors++; $display("FAIL rstmid_rerun: lat=%0d bytes=%h expected 17 000000", lat, {mem[54], mem[55], mem[56]}); end
  endtask

  task automatic test_start_busy;
    setup_img(54, 1, 1); put_px(54, 8'd100, 8'd128, 8'd200);
    start = 1'b1; thr = 8'd128;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; lat = 1;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; thr = 8'd255;
      @(negedge clk); lat++;
    end
    start = 1'b0;
    while (!done && lat < 3000) begin @(negedge clk); lat++; end
    checks++; if (lat !== 17) begin errors++; $display("FAIL busy_start_latency: got %0d expected 17", lat); end
    n = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (busy) n++; end
    checks++; if (n !== 0) begin errors++; $display("FAIL busy_start_retrigger: busy cycles %0d expected 0", n); end
    checks++; if ({mem[54], mem[55], mem[56]} !== 24'hFFFFFF) begin
      errors++; $display("FAIL busy_start_thr: got %h expected ffffff", {mem[54], mem[55], mem[56]}); end
  endtask

  task automatic test_back_to_back;
    setup_img(54, 1, 1); put_px(54, 8'd255, 8'd255, 8'd255);
    start = 1'b1; thr = 8'd128; n = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (done) n++; end
    start = 1'b0;
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", n); end
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || n >= 100) begin
      errors++; $display("FAIL b2b_drain: busy=%b wait=%0d expected 0 below 100", busy, n); end
  endtask

  initial begin
    test_reset;
    test_dark_pixel;
    test_white_pixel;
    test_threshold;
    test_2x2;
    test_size_err;
    test_empty;
    test_reset_mid;
    test_start_busy;
    test_back_to_back;
    checks++; if (conflicts !== 0) begin errors++; $display("FAIL port_conflict: got %0d expected 0", conflicts); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
